// File: rtl/menu_pkg.sv
// Shared types and constants for the battle command menu.
// Frame geometry and item outline thickness live here so the sprites and the top agree.
package menu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2,
        CANCEL = 2'd3
    } menu_state_t;

    localparam logic [1:0]  KEY_NONE  = 2'b00;
    localparam logic [1:0]  KEY_LEFT  = 2'b01;
    localparam logic [1:0]  KEY_RIGHT = 2'b10;

    localparam logic [11:0] COLOR_NONE = 12'h000;
    localparam logic [11:0] COLOR_DIS  = 12'h444;

    localparam int ITEM_BORDER = 2;

    // Frame box surrounding the item row; IDLE shows only its bottom FRAME_T rows.
    localparam int FRAME_X0 = 100;
    localparam int FRAME_X1 = 879;
    localparam int FRAME_Y0 = 690;
    localparam int FRAME_Y1 = 765;
    localparam int FRAME_T  = 3;

endpackage

// File: rtl/menu_item_sprite.sv
// One menu item box outline; purely combinational hit test and colour select.
// The parent registers the result, so this adds no latency of its own.
module menu_item_sprite
    import menu_pkg::*;
#(
    parameter int          X           = 0,
    parameter int          Y           = 0,
    parameter int          W           = 110,
    parameter int          H           = 42,
    parameter logic [11:0] FRAME_COLOR = 12'hFFF,
    parameter logic [11:0] SEL_COLOR   = 12'hFF0
) (
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        selected_in,
    input  logic        enabled_in,
    output logic [11:0] pixel_out,
    output logic        hit_out
);

    localparam logic [10:0] XO0 = 11'(X);
    localparam logic [10:0] XO1 = 11'(X + W - 1);
    localparam logic [10:0] XI0 = 11'(X + ITEM_BORDER);
    localparam logic [10:0] XI1 = 11'(X + W - 1 - ITEM_BORDER);
    localparam logic [9:0]  YO0 = 10'(Y);
    localparam logic [9:0]  YO1 = 10'(Y + H - 1);
    localparam logic [9:0]  YI0 = 10'(Y + ITEM_BORDER);
    localparam logic [9:0]  YI1 = 10'(Y + H - 1 - ITEM_BORDER);

    logic w_outer;
    logic w_inner;

    assign w_outer = (hcount_in >= XO0) && (hcount_in <= XO1) &&
                     (vcount_in >= YO0) && (vcount_in <= YO1);
    assign w_inner = (hcount_in >= XI0) && (hcount_in <= XI1) &&
                     (vcount_in >= YI0) && (vcount_in <= YI1);

    assign hit_out   = w_outer && !w_inner;
    assign pixel_out = !hit_out    ? COLOR_NONE :
                       selected_in ? SEL_COLOR  :
                       enabled_in  ? FRAME_COLOR : COLOR_DIS;

endmodule

// File: rtl/battle_menu_ctrl.sv
// N-item battle command menu: arm on state entry, edge-detected cursor, confirm/cancel/timeout.
// Status outputs and pixel_out are registered (pixel one cycle behind hcount/vcount).
module battle_menu_ctrl
    import menu_pkg::*;
#(
    parameter int          NUM_ITEMS     = 4,
    parameter int          ITEM_X0       = 126,
    parameter int          ITEM_PITCH    = 206,
    parameter int          ITEM_Y        = 707,
    parameter int          ITEM_W        = 110,
    parameter int          ITEM_H        = 42,
    parameter logic [3:0]  TRIGGER_STATE = 4'h0,
    parameter int          WRAP          = 1,
    parameter int          TIMEOUT_CYC   = 32500000,
    parameter logic [11:0] FRAME_COLOR   = 12'hFFF,
    parameter logic [11:0] SEL_COLOR     = 12'hFF0,
    localparam int         IDX_W         = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [10:0]          hcount_in,
    input  logic [9:0]           vcount_in,
    input  logic [3:0]           state_in,
    input  logic [1:0]           key_input_in,
    input  logic                 decide_in,
    input  logic                 cancel_in,
    input  logic [NUM_ITEMS-1:0] enable_mask_in,
    output logic                 busy_out,
    output logic                 finished_out,
    output logic                 cancelled_out,
    output logic [IDX_W-1:0]     sel_idx_out,
    output logic [11:0]          pixel_out
);

    localparam int          CNT_W      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam int unsigned CNT_LAST_I = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_LAST_I[CNT_W-1:0];

    localparam logic [10:0] FX0  = 11'(FRAME_X0);
    localparam logic [10:0] FX1  = 11'(FRAME_X1);
    localparam logic [10:0] FXI0 = 11'(FRAME_X0 + FRAME_T);
    localparam logic [10:0] FXI1 = 11'(FRAME_X1 - FRAME_T);
    localparam logic [9:0]  FY0  = 10'(FRAME_Y0);
    localparam logic [9:0]  FY1  = 10'(FRAME_Y1);
    localparam logic [9:0]  FYI0 = 10'(FRAME_Y0 + FRAME_T);
    localparam logic [9:0]  FYI1 = 10'(FRAME_Y1 - FRAME_T);

    menu_state_t      r_state;
    logic [3:0]       r_old_state;
    logic [1:0]       r_old_key;
    logic             r_old_decide;
    logic             r_old_cancel;
    logic [IDX_W-1:0] r_sel;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_fin;
    logic             r_can;
    logic [11:0]      r_pix;

    logic w_key_ev, w_dec_ev, w_can_ev, w_any_ev;
    logic w_arm, w_cur_en, w_timeout;
    logic w_in_outer, w_in_inner, w_frame_hit;
    logic [11:0] w_pix_next;
    logic [NUM_ITEMS-1:0]          w_item_hit;
    logic [NUM_ITEMS-1:0][11:0]    w_item_pix;
    logic [NUM_ITEMS:0][11:0]      w_item_chain;

    function automatic logic [IDX_W-1:0] f_lowest(input logic [NUM_ITEMS-1:0] mask);
        logic [IDX_W-1:0] res;
        logic [IDX_W-1:0] ui;
        res = '0;
        for (int i = NUM_ITEMS - 1; i >= 0; i--) begin
            ui = IDX_W'(i);
            if (mask[ui]) res = ui;
        end
        return res;
    endfunction

    // Nearest enabled item in the given direction; unchanged when none qualifies.
    function automatic logic [IDX_W-1:0] f_step(input logic [IDX_W-1:0]     cur,
                                                 input logic [NUM_ITEMS-1:0] mask,
                                                 input logic                 right,
                                                 input logic                 wrap);
        logic [IDX_W-1:0] res;
        logic [IDX_W-1:0] ui;
        logic             found;
        int               pos;
        res   = cur;
        found = 1'b0;
        for (int k = 1; k < NUM_ITEMS; k++) begin
            pos = right ? int'(cur) + k : int'(cur) - k;
            if (wrap) pos = (pos + NUM_ITEMS) % NUM_ITEMS;
            ui = IDX_W'(pos);
            if (!found && pos >= 0 && pos < NUM_ITEMS && mask[ui]) begin
                res   = ui;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    assign w_key_ev  = (r_old_key == KEY_NONE) &&
                       (key_input_in == KEY_LEFT || key_input_in == KEY_RIGHT);
    assign w_dec_ev  = decide_in && !r_old_decide;
    assign w_can_ev  = cancel_in && !r_old_cancel;
    assign w_any_ev  = w_key_ev || w_dec_ev || w_can_ev;
    assign w_arm     = (state_in == TRIGGER_STATE) && (r_old_state != TRIGGER_STATE);
    assign w_cur_en  = enable_mask_in[r_sel];
    assign w_timeout = (TIMEOUT_CYC > 0) && !w_any_ev && (r_cnt == CNT_LAST);

    assign w_item_chain[NUM_ITEMS] = COLOR_NONE;

    for (genvar g = 0; g < NUM_ITEMS; g++) begin : g_item
        menu_item_sprite #(
            .X           (ITEM_X0 + g * ITEM_PITCH),
            .Y           (ITEM_Y),
            .W           (ITEM_W),
            .H           (ITEM_H),
            .FRAME_COLOR (FRAME_COLOR),
            .SEL_COLOR   (SEL_COLOR)
        ) u_item (
            .hcount_in   (hcount_in),
            .vcount_in   (vcount_in),
            .selected_in (r_sel == IDX_W'(g)),
            .enabled_in  (enable_mask_in[g]),
            .pixel_out   (w_item_pix[g]),
            .hit_out     (w_item_hit[g])
        );
        // Lowest index wins if boxes ever overlap.
        assign w_item_chain[g] = w_item_hit[g] ? w_item_pix[g] : w_item_chain[g+1];
    end

    assign w_in_outer = (hcount_in >= FX0) && (hcount_in <= FX1) &&
                        (vcount_in >= FY0) && (vcount_in <= FY1);
    assign w_in_inner = (hcount_in >= FXI0) && (hcount_in <= FXI1) &&
                        (vcount_in >= FYI0) && (vcount_in <= FYI1);
    assign w_frame_hit = (r_state == ACTIVE) ? (w_in_outer && !w_in_inner)
                                             : (w_in_outer && vcount_in > FYI1);

    assign w_pix_next = ((r_state == ACTIVE) && (|w_item_hit)) ? w_item_chain[0] :
                        w_frame_hit                            ? FRAME_COLOR     : COLOR_NONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_old_state  <= 4'hA;
            r_old_key    <= KEY_NONE;
            r_old_decide <= 1'b0;
            r_old_cancel <= 1'b0;
            r_sel        <= f_lowest(enable_mask_in);
            r_cnt        <= '0;
            r_busy       <= 1'b0;
            r_fin        <= 1'b0;
            r_can        <= 1'b0;
            r_pix        <= COLOR_NONE;
        end else begin
            r_old_state  <= state_in;
            r_old_key    <= key_input_in;
            r_old_decide <= decide_in;
            r_old_cancel <= cancel_in;
            r_fin        <= 1'b0;
            r_can        <= 1'b0;
            r_pix        <= w_pix_next;
            case (r_state)
                IDLE: begin
                    if (w_arm) begin
                        r_state <= ACTIVE;
                        r_busy  <= 1'b1;
                        r_sel   <= f_lowest(enable_mask_in);
                        r_cnt   <= '0;
                    end
                end
                ACTIVE: begin
                    if (w_dec_ev && w_cur_en) begin
                        r_state <= DONE;
                        r_fin   <= 1'b1;
                        r_busy  <= 1'b0;
                    end else if (w_can_ev) begin
                        r_state <= CANCEL;
                        r_can   <= 1'b1;
                        r_busy  <= 1'b0;
                    end else if (w_timeout) begin
                        r_busy  <= 1'b0;
                        r_state <= w_cur_en ? DONE : CANCEL;
                        r_fin   <= w_cur_en;
                        r_can   <= !w_cur_en;
                    end else begin
                        r_cnt <= w_any_ev ? '0 : r_cnt + CNT_W'(1);
                        // A freshly disabled cursor item is repaired before any key move.
                        if (!w_cur_en)
                            r_sel <= f_step(r_sel, enable_mask_in, 1'b1, 1'b1);
                        else if (w_key_ev)
                            r_sel <= f_step(r_sel, enable_mask_in,
                                            key_input_in == KEY_RIGHT, WRAP != 0);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy_out      = r_busy;
    assign finished_out  = r_fin;
    assign cancelled_out = r_can;
    assign sel_idx_out   = r_sel;
    assign pixel_out     = r_pix;

endmodule

// File: tb/tb_battle_menu_ctrl.sv
// Two menu instances (wrap+timeout 50, saturate+no timeout) driven by shared directed stimulus,
// checked every cycle against a behavioural model plus hand-computed literal expectations.
module tb_battle_menu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  st;
    logic [1:0]  key;
    logic        dec;
    logic        can;
    logic [3:0]  mask;
    logic [10:0] hc;
    logic [9:0]  vc;

    logic [1:0]  d_busy, d_fin, d_can;
    logic [1:0]  d_sel [2];
    logic [11:0] d_pix [2];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    battle_menu_ctrl #(.WRAP(1), .TIMEOUT_CYC(50)) u0 (
        .clk(clk), .rst(rst), .hcount_in(hc), .vcount_in(vc), .state_in(st),
        .key_input_in(key), .decide_in(dec), .cancel_in(can), .enable_mask_in(mask),
        .busy_out(d_busy[0]), .finished_out(d_fin[0]), .cancelled_out(d_can[0]),
        .sel_idx_out(d_sel[0]), .pixel_out(d_pix[0])
    );

    battle_menu_ctrl #(.WRAP(0), .TIMEOUT_CYC(0)) u1 (
        .clk(clk), .rst(rst), .hcount_in(hc), .vcount_in(vc), .state_in(st),
        .key_input_in(key), .decide_in(dec), .cancel_in(can), .enable_mask_in(mask),
        .busy_out(d_busy[1]), .finished_out(d_fin[1]), .cancelled_out(d_can[1]),
        .sel_idx_out(d_sel[1]), .pixel_out(d_pix[1])
    );

    task automatic chk(input string name, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, got, exp);
        end
    endtask

    function automatic bit en(input logic [3:0] m, input int i);
        return ((m >> i) & 4'd1) != 4'd0;
    endfunction

    function automatic int lowest(input logic [3:0] m);
        for (int i = 0; i < 4; i++) if (en(m, i)) return i;
        return 0;
    endfunction

    // Scan the enabled list for the neighbour; fall back to wrap-around, then to staying put.
    function automatic int move(input int cur, input logic [3:0] m, input bit right, input bit wrap);
        if (right) begin
            for (int i = cur + 1; i < 4; i++) if (en(m, i)) return i;
            if (wrap) for (int i = 0; i < cur; i++) if (en(m, i)) return i;
        end else begin
            for (int i = cur - 1; i >= 0; i--) if (en(m, i)) return i;
            if (wrap) for (int i = 3; i > cur; i--) if (en(m, i)) return i;
        end
        return cur;
    endfunction

    function automatic logic [11:0] render(input bit active, input int sel, input logic [3:0] m,
                                           input int h, input int v);
        bit fo, fi;
        if (active) begin
            for (int i = 0; i < 4; i++) begin
                int  x0 = 126 + 206 * i;
                bit  o  = h >= x0 && h < x0 + 110 && v >= 707 && v < 749;
                bit  n  = h >= x0 + 2 && h < x0 + 108 && v >= 709 && v < 747;
                if (o && !n) return (i == sel) ? 12'hFF0 : en(m, i) ? 12'hFFF : 12'h444;
            end
        end
        fo = h >= 100 && h <= 879 && v >= 690 && v <= 765;
        fi = h >= 103 && h <= 876 && v >= 693 && v <= 762;
        if (active ? (fo && !fi) : (fo && v >= 763)) return 12'hFFF;
        return 12'h000;
    endfunction

    localparam int P_IDLE = 0, P_ACT = 1, P_EXIT = 2;
    int          m_phase [2];
    int          m_sel   [2];
    int          m_idle  [2];
    bit          m_busy  [2];
    bit          m_fin   [2];
    bit          m_can   [2];
    logic [11:0] m_pix   [2];
    logic [3:0]  old_st;
    logic [1:0]  old_key;
    logic        old_dec, old_can;

    always @(posedge clk) begin
        bit key_ev, dec_ev, can_ev, any_ev, cur_en, wrap;
        int to;
        key_ev = (old_key == 2'b00) && (key == 2'b01 || key == 2'b10);
        dec_ev = dec && !old_dec;
        can_ev = can && !old_can;
        any_ev = key_ev || dec_ev || can_ev;
        for (int u = 0; u < 2; u++) begin
            wrap = (u == 0);
            to   = (u == 0) ? 50 : 0;
            if (rst) begin
                m_phase[u] = P_IDLE; m_busy[u] = 0; m_fin[u] = 0; m_can[u] = 0;
                m_sel[u] = lowest(mask); m_idle[u] = 0; m_pix[u] = 12'h000;
            end else begin
                m_pix[u] = render(m_phase[u] == P_ACT, m_sel[u], mask, int'(hc), int'(vc));
                m_fin[u] = 0;
                m_can[u] = 0;
                cur_en   = en(mask, m_sel[u]);
                if (m_phase[u] == P_EXIT) begin
                    m_phase[u] = P_IDLE;
                end else if (m_phase[u] == P_IDLE) begin
                    if (st == 4'h0 && old_st != 4'h0) begin
                        m_phase[u] = P_ACT; m_busy[u] = 1; m_sel[u] = lowest(mask); m_idle[u] = 0;
                    end
                end else if (dec_ev && cur_en) begin
                    m_phase[u] = P_EXIT; m_busy[u] = 0; m_fin[u] = 1;
                end else if (can_ev) begin
                    m_phase[u] = P_EXIT; m_busy[u] = 0; m_can[u] = 1;
                end else begin
                    m_idle[u] = any_ev ? 0 : m_idle[u] + 1;
                    if (to != 0 && m_idle[u] == to) begin
                        m_phase[u] = P_EXIT; m_busy[u] = 0;
                        m_fin[u] = cur_en; m_can[u] = !cur_en;
                    end else if (!cur_en) begin
                        m_sel[u] = move(m_sel[u], mask, 1'b1, 1'b1);
                    end else if (key_ev) begin
                        m_sel[u] = move(m_sel[u], mask, key == 2'b10, wrap);
                    end
                end
            end
        end
        old_st  = rst ? 4'hA : st;
        old_key = rst ? 2'b00 : key;
        old_dec = rst ? 1'b0 : dec;
        old_can = rst ? 1'b0 : can;
        #1;
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("u%0d busy", u),      int'(d_busy[u]), int'(m_busy[u]));
            chk($sformatf("u%0d finished", u),  int'(d_fin[u]),  int'(m_fin[u]));
            chk($sformatf("u%0d cancelled", u), int'(d_can[u]),  int'(m_can[u]));
            chk($sformatf("u%0d sel_idx", u),   int'(d_sel[u]),  m_sel[u]);
            chk($sformatf("u%0d pixel", u),     int'(d_pix[u]),  int'(m_pix[u]));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [1:0] k);
        key = k;
        cyc(1);
        key = 2'b00;
        cyc(1);
    endtask

    initial begin
        rst = 1'b1; st = 4'd5; key = 2'b00; dec = 1'b0; can = 1'b0;
        mask = 4'b1100; hc = 11'd0; vc = 10'd0;
        cyc(3);
        chk("reset sel lowest enabled", int'(d_sel[0]), 2);
        mask = 4'b1111;
        cyc(1);
        chk("reset sel", int'(d_sel[0]), 0);
        chk("reset busy", int'(d_busy[0]), 0);
        chk("reset pixel", int'(d_pix[0]), 0);

        rst = 1'b0; hc = 11'd200; vc = 10'd765;
        cyc(2);
        chk("idle bottom frame", int'(d_pix[0]), 'hFFF);
        vc = 10'd690;
        cyc(1);
        chk("idle top frame hidden", int'(d_pix[0]), 0);
        hc = 11'd126; vc = 10'd707;
        cyc(1);
        chk("idle item hidden", int'(d_pix[0]), 0);

        st = 4'd0;
        cyc(1);
        chk("arm busy", int'(d_busy[0]), 1);
        press(2'b10);
        press(2'b10);
        chk("two rights", int'(d_sel[0]), 2);
        dec = 1'b1;
        cyc(1);
        chk("decide finished", int'(d_fin[0]), 1);
        chk("decide busy", int'(d_busy[0]), 0);
        chk("decide sel", int'(d_sel[0]), 2);
        dec = 1'b0;
        cyc(1);
        chk("finished one cycle", int'(d_fin[0]), 0);
        st = 4'd5;
        cyc(1);
        chk("sel held in idle", int'(d_sel[0]), 2);

        mask = 4'b1011; hc = 11'd538; vc = 10'd707; st = 4'd0;
        cyc(2);
        chk("disabled item colour", int'(d_pix[0]), 'h444);
        press(2'b10);
        press(2'b10);
        chk("skip disabled u0", int'(d_sel[0]), 3);
        chk("skip disabled u1", int'(d_sel[1]), 3);
        press(2'b10);
        chk("wrap right", int'(d_sel[0]), 0);
        chk("saturate right", int'(d_sel[1]), 3);
        can = 1'b1;
        cyc(1);
        chk("cancel pulse", int'(d_can[0]), 1);
        chk("cancel no finish", int'(d_fin[0]), 0);
        chk("cancel busy", int'(d_busy[0]), 0);
        can = 1'b0;
        cyc(1);
        chk("cancel one cycle", int'(d_can[0]), 0);

        st = 4'd5; cyc(1); st = 4'd0; cyc(1);
        press(2'b10);
        mask = 4'b1001;
        cyc(1);
        chk("mask drop moves right", int'(d_sel[0]), 3);
        key = 2'b01; dec = 1'b1; can = 1'b1;
        cyc(1);
        chk("decide beats cancel", int'(d_fin[0]), 1);
        chk("decide beats cancel c", int'(d_can[0]), 0);
        chk("decide pre-move index", int'(d_sel[0]), 3);
        key = 2'b00; dec = 1'b0; can = 1'b0;
        cyc(1);

        st = 4'd5; mask = 4'b1111; cyc(1); st = 4'd0; cyc(1);
        key = 2'b01;
        cyc(1);
        chk("saturate left", int'(d_sel[1]), 0);
        chk("wrap left", int'(d_sel[0]), 3);
        key = 2'b00;
        cyc(1);
        key = 2'b10;
        cyc(100);
        chk("held key one step", int'(d_sel[1]), 1);
        key = 2'b00;
        cyc(1);
        can = 1'b1; cyc(1);
        chk("u1 cancel", int'(d_can[1]), 1);
        can = 1'b0; cyc(1);

        st = 4'd5; cyc(1); st = 4'd0; cyc(1);
        cyc(49);
        chk("no timeout at 49", int'(d_fin[0]), 0);
        chk("busy at 49", int'(d_busy[0]), 1);
        cyc(1);
        chk("timeout at 50", int'(d_fin[0]), 1);
        chk("timeout sel", int'(d_sel[0]), 0);
        st = 4'd5; cyc(1); st = 4'd0; cyc(1);
        cyc(39);
        key = 2'b10; cyc(1); key = 2'b00;
        chk("key at 40 moves", int'(d_sel[0]), 1);
        cyc(49);
        chk("restart no timeout", int'(d_fin[0]), 0);
        chk("restart busy", int'(d_busy[0]), 1);
        cyc(1);
        chk("restart timeout", int'(d_fin[0]), 1);
        chk("restart timeout sel", int'(d_sel[0]), 1);

        st = 4'd5; cyc(1); st = 4'd0; cyc(1);
        press(2'b01);
        chk("cursor at 3", int'(d_sel[0]), 3);
        rst = 1'b1; st = 4'd5;
        cyc(1);
        chk("mid reset busy", int'(d_busy[0]), 0);
        chk("mid reset sel", int'(d_sel[0]), 0);
        chk("mid reset fin", int'(d_fin[0]), 0);
        chk("mid reset can", int'(d_can[0]), 0);
        rst = 1'b0; hc = 11'd126; vc = 10'd707;
        cyc(1);
        st = 4'd0;
        cyc(2);
        chk("item0 selected colour", int'(d_pix[0]), 'hFF0);
        hc = 11'd200; vc = 10'd690;
        cyc(1);
        chk("active top frame", int'(d_pix[0]), 'hFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
